// File: rtl/load_store_unit.sv
// Load/store unit between a request/response handshake and a single-cycle-latency byte-enabled RAM.
// Stores are lane-replicated with byte enables; loads are lane-selected and sign- or zero-extended.
module load_store_unit #(
    parameter int DEPTH         = 16384,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic [3:0]                 mem_we,
    output logic [ADDRESS_WIDTH-1:2]   mem_addr,
    output logic [31:0]                mem_data,
    input  logic [31:0]                mem_q
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t state, next_state;

    logic        accept;
    logic        req_err;
    logic [3:0]  store_we;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    logic        op_we;
    logic        op_unsigned;
    logic [1:0]  op_size;
    logic [1:0]  op_lane;

    // Misalignment, illegal size, or any address bit above the RAM's range.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = req_addr[0];
            2'd2:    req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ((req_addr >> ADDRESS_WIDTH) != 32'd0) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        store_we   = 4'b1111;
        store_data = req_wdata;
        case (req_size)
            2'd0: begin
                store_data = {4{req_wdata[7:0]}};
                store_we   = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                store_data = {2{req_wdata[15:0]}};
                store_we   = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = req_wdata;
                store_we   = 4'b1111;
            end
        endcase
    end

    // Read data is formatted from mem_q using the lane and size captured at accept.
    always_comb begin
        load_byte = mem_q[{op_lane, 3'b000} +: 8];
        load_half = op_lane[1] ? mem_q[31:16] : mem_q[15:0];
        load_data = mem_q;
        case (op_size)
            2'd0:    load_data = op_unsigned ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'd1:    load_data = op_unsigned ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_data = mem_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: next_state = op_we ? RESP : WAIT;
            WAIT:   next_state = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // mem_we is a one-cycle pulse: set only on the accept edge, so it is live only in ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we      <= 4'b0000;
            mem_addr    <= '0;
            mem_data    <= 32'd0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            op_we       <= 1'b0;
            op_unsigned <= 1'b0;
            op_size     <= 2'd0;
            op_lane     <= 2'd0;
        end else begin
            mem_we <= 4'b0000;
            if (accept) begin
                rsp_err   <= req_err;
                rsp_rdata <= 32'd0;
                if (!req_err) begin
                    mem_addr    <= req_addr[ADDRESS_WIDTH-1:2];
                    mem_data    <= store_data;
                    mem_we      <= req_we ? store_we : 4'b0000;
                    op_we       <= req_we;
                    op_unsigned <= req_unsigned;
                    op_size     <= req_size;
                    op_lane     <= req_addr[1:0];
                end
            end else if (state == WAIT) begin
                rsp_rdata <= load_data;
            end
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 16384, meaning the size of the byte address space served by the attached RAM.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default $clog2(DEPTH), meaning the byte-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: request present.
REQ-006 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-009 SHALL have port req_unsigned, input, 1: load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port req_addr, input, 32: byte address.
REQ-011 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1: response present.
REQ-013 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-014 SHALL have port rsp_rdata, output, 32: formatted load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1: request was misaligned, out of range, or of illegal size.
REQ-016 SHALL have port mem_we, output, 4: per-byte write enables to the RAM.
REQ-017 SHALL have port mem_addr, output, ADDRESS_WIDTH-1:2: word address to the RAM.
REQ-018 SHALL have port mem_data, output, 32: lane-replicated write data to the RAM.
REQ-019 SHALL have port mem_q, input, 32: RAM read word, valid one cycle after the RAM samples mem_addr.

Function
REQ-020 SHALL implement the states IDLE, ACCESS, WAIT and RESP.
REQ-021 SHALL drive req_ready = 1 only in IDLE.
REQ-022 SHALL accept a request at a rising edge where req_valid && req_ready.
REQ-023 SHALL, on accepting a request that has an error, go IDLE->RESP with rsp_err=1 and rsp_rdata=0, and leave mem_we at 0 throughout.
REQ-024 SHALL flag an error for any of: size 3; halfword with addr[0]=1; word with addr[1:0]!=0; req_addr[31:ADDRESS_WIDTH] nonzero.
REQ-025 SHALL, on accepting a valid request, go IDLE->ACCESS and register mem_addr=req_addr[ADDRESS_WIDTH-1:2], mem_data and mem_we.
REQ-026 SHALL drive mem_we nonzero only during ACCESS for stores, and 0 in every other state.
REQ-027 SHALL hold mem_addr at its last value outside ACCESS.
REQ-028 SHALL form store lanes as: byte: mem_data={4{wdata[7:0]}}, mem_we=4'b0001<<addr[1:0]; half: mem_data={2{wdata[15:0]}}, mem_we=addr[1]?1100:0011; word: mem_data=wdata, mem_we=1111.
REQ-029 SHALL step stores ACCESS->RESP, so rsp_valid rises 2 cycles after acceptance, with rsp_rdata=0 and rsp_err=0.
REQ-030 SHALL step loads ACCESS->WAIT->RESP, capturing at the WAIT edge mem_q lane-selected by addr[1:0] (bytes) or addr[1] (halves) and then zero- or sign-extended; rsp_valid rises 3 cycles after acceptance.
REQ-031 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then go RESP->IDLE at that edge.
REQ-032 SHALL NOT accept a new request in the same cycle the response is consumed; the next accept is earliest one cycle later.
REQ-033 SHALL ignore req_* in every state other than IDLE.

Reset
REQ-034 SHALL, while rst=1, immediately force state=IDLE, mem_we=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0 and mem_data=0.
REQ-035 SHALL abandon any in-flight request when rst asserts mid-operation, and SHALL generate no response for it.
REQ-036 SHALL assert req_ready in the first cycle after rst deasserts.

Verification
REQ-037 SHALL pass: store word 0xDEADBEEF @0x10, then load word @0x10 -> mem_we=1111 and mem_addr=4 in ACCESS; load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-038 SHALL pass: store byte 0x80 @0x13, then load byte signed @0x13 -> mem_we=1000, mem_data=0x80808080; load returns 0xFFFFFF80; unsigned load returns 0x00000080.
REQ-039 SHALL pass: load half signed @0x12 with mem_q=0x8001xxxx -> rsp_rdata=0xFFFF8001; load @0x11 as half -> rsp_err=1, mem_we stays 0, no RAM access.
REQ-040 SHALL pass: addr=DEPTH (0x4000), or req_size=3 -> rsp_err=1, rsp_rdata=0, response 1 cycle after accept.
REQ-041 SHALL pass: rsp_ready held 0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; req_ready=1 the cycle after rsp_ready=1.
REQ-042 SHALL pass: rst pulsed during the ACCESS cycle of a store -> mem_we drops to 0 asynchronously, no rsp_valid, and req_ready=1 after release.
